// File: rtl/tracker_pkg.sv
// Shared frame geometry, FSM state encoding and RGB565 field layout for the colour tracker.
package tracker_pkg;

  // Native sensor frame size.
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;

  // Coordinate and match-count widths.
  localparam int COORD_W = 10;
  localparam int COUNT_W = 17;

  // Accumulator clear value for the running minimum; any real coordinate is below it.
  localparam logic [COORD_W-1:0] MIN_CLEAR = 10'd511;

  // RGB565 field positions (LSB and width of each channel).
  localparam int R_LO = 11;
  localparam int R_W  = 5;
  localparam int G_LO = 5;
  localparam int G_W  = 6;
  localparam int B_LO = 0;
  localparam int B_W  = 5;

  // Tracker frame-level state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_classifier.sv
// Combinational colour-threshold test on one RGB565 pixel.
module pixel_classifier
  import tracker_pkg::*;
#(
  parameter int R_MIN = 20,
  parameter int G_MAX = 24,
  parameter int B_MAX = 12
) (
  input  logic [15:0] pix_i,
  output logic        match_o
);

  localparam logic [R_W-1:0] R_MIN_L = R_W'(R_MIN);
  localparam logic [G_W-1:0] G_MAX_L = G_W'(G_MAX);
  localparam logic [B_W-1:0] B_MAX_L = B_W'(B_MAX);

  logic [R_W-1:0] red;
  logic [G_W-1:0] green;
  logic [B_W-1:0] blue;

  assign red     = pix_i[R_LO +: R_W];
  assign green   = pix_i[G_LO +: G_W];
  assign blue    = pix_i[B_LO +: B_W];

  // Strongly red, weakly green and blue.
  assign match_o = (red >= R_MIN_L) && (green <= G_MAX_L) && (blue <= B_MAX_L);

endmodule

// File: rtl/color_tracker_core.sv
// Single-colour object tracker: accumulates the bounding box of matching pixels over
// one raster frame and publishes centre and half-extent once the frame completes.
module color_tracker_core
  import tracker_pkg::*;
#(
  parameter int R_MIN        = 20,
  parameter int G_MAX        = 24,
  parameter int B_MAX        = 12,
  parameter int MIN_PIXELS   = 16,
  parameter int FRAME_WIDTH  = FRAME_W,
  parameter int FRAME_HEIGHT = FRAME_H
) (
  input  logic               cam_clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [15:0]        pix_data,
  output logic [COORD_W-1:0] track_x,
  output logic [COORD_W-1:0] track_y,
  output logic [COORD_W-1:0] box_half_w,
  output logic [COORD_W-1:0] box_half_h,
  output logic               track_valid,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(FRAME_HEIGHT - 1);
  localparam logic [COUNT_W-1:0] COUNT_MIN = COUNT_W'(MIN_PIXELS);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [COORD_W-1:0]   track_x_q, track_x_d, track_y_q, track_y_d;
  logic [COORD_W-1:0]   half_w_q, half_w_d, half_h_q, half_h_d;
  logic                 track_valid_q, track_valid_d;
  logic                 frame_done_q, frame_done_d;

  logic                 pix_match;
  logic                 accept;
  logic                 enough;
  logic [COORD_W:0]     sum_x, sum_y, span_x, span_y;

  pixel_classifier #(
    .R_MIN (R_MIN),
    .G_MAX (G_MAX),
    .B_MAX (B_MAX)
  ) u_classifier (
    .pix_i   (pix_data),
    .match_o (pix_match)
  );

  // A pixel counts when we are mid-frame, or when it arrives with the frame_start that opens a frame.
  assign accept = pix_valid && (frame_start || (state_q == ACCUM));

  // One extra bit so the centre sum of two 10-bit coordinates cannot overflow.
  assign sum_x  = {1'b0, min_x_q} + {1'b0, max_x_q};
  assign sum_y  = {1'b0, min_y_q} + {1'b0, max_y_q};
  assign span_x = {1'b0, max_x_q} - {1'b0, min_x_q};
  assign span_y = {1'b0, max_y_q} - {1'b0, min_y_q};
  assign enough = (count_q >= COUNT_MIN);

  // Next-state logic: frame_start restarts everything, then the current pixel (if any) is folded in.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch); later
    // statements deliberately read the blocking updates made above them.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    count_d = count_q;

    if (frame_start) begin
      state_d = ACCUM;
      x_d     = '0;
      y_d     = '0;
      min_x_d = MIN_CLEAR;
      max_x_d = '0;
      min_y_d = MIN_CLEAR;
      max_y_d = '0;
      count_d = '0;
    end else if (state_q == COMMIT) begin
      state_d = IDLE;
    end

    if (accept) begin
      if (pix_match) begin
        if (x_d < min_x_d) min_x_d = x_d;
        if (x_d > max_x_d) max_x_d = x_d;
        if (y_d < min_y_d) min_y_d = y_d;
        if (y_d > max_y_d) max_y_d = y_d;
        if (count_d != '1) count_d = count_d + 1'b1;
      end
      if (x_d == X_LAST) begin
        if (y_d == Y_LAST) state_d = COMMIT;
        x_d = '0;
        y_d = y_d + 1'b1;
      end else begin
        x_d = x_d + 1'b1;
      end
    end
  end

  // Publish results during the single COMMIT cycle; geometry holds when the detection is too small.
  always_comb begin
    track_x_d     = track_x_q;
    track_y_d     = track_y_q;
    half_w_d      = half_w_q;
    half_h_d      = half_h_q;
    track_valid_d = track_valid_q;
    frame_done_d  = 1'b0;
    if (state_q == COMMIT) begin
      frame_done_d  = 1'b1;
      track_valid_d = enough;
      if (enough) begin
        track_x_d = COORD_W'(sum_x >> 1);
        track_y_d = COORD_W'(sum_y >> 1);
        half_w_d  = COORD_W'(span_x >> 1);
        half_h_d  = COORD_W'(span_y >> 1);
      end
    end
  end

  // Frame scan state and accumulators.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      min_x_q <= MIN_CLEAR;
      max_x_q <= '0;
      min_y_q <= MIN_CLEAR;
      max_y_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      count_q <= count_d;
    end
  end

  // Output registers, cleared asynchronously by reset.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      track_x_q     <= '0;
      track_y_q     <= '0;
      half_w_q      <= '0;
      half_h_q      <= '0;
      track_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      track_x_q     <= track_x_d;
      track_y_q     <= track_y_d;
      half_w_q      <= half_w_d;
      half_h_q      <= half_h_d;
      track_valid_q <= track_valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign track_x     = track_x_q;
  assign track_y     = track_y_q;
  assign box_half_w  = half_w_q;
  assign box_half_h  = half_h_q;
  assign track_valid = track_valid_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_color_tracker_core.sv
// Scoreboard bench for color_tracker_core on a reduced 40x30 frame. The driver builds each frame
// in a buffer, a reference model derives the expected result from that buffer, and a monitor
// compares on every frame_done and checks output stability on every other cycle.
module tb_color_tracker_core;

  localparam int FW         = 40;
  localparam int FH         = 30;
  localparam int NPIX       = FW * FH;
  localparam int R_MIN      = 20;
  localparam int G_MAX      = 24;
  localparam int B_MAX      = 12;
  localparam int MIN_PIX    = 16;
  localparam int MAX_CYCLES = 60000;

  typedef struct {
    logic [9:0] tx;
    logic [9:0] ty;
    logic [9:0] hw;
    logic [9:0] hh;
    logic       tv;
    int         due;
  } exp_t;

  logic        cam_clk     = 1'b0;
  logic        rst_n       = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid   = 1'b0;
  logic [15:0] pix_data    = 16'h0;
  logic [9:0]  track_x, track_y, box_half_w, box_half_h;
  logic        track_valid, frame_done;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  exp_t        sb_q[$];
  exp_t        cur_exp;
  exp_t        last_exp;
  logic [15:0] fb [NPIX];

  color_tracker_core #(
    .R_MIN        (R_MIN),
    .G_MAX        (G_MAX),
    .B_MAX        (B_MAX),
    .MIN_PIXELS   (MIN_PIX),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .cam_clk     (cam_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .track_x     (track_x),
    .track_y     (track_y),
    .box_half_w  (box_half_w),
    .box_half_h  (box_half_h),
    .track_valid (track_valid),
    .frame_done  (frame_done)
  );

  always #5 cam_clk = ~cam_clk;
  always @(posedge cam_clk) cyc <= cyc + 1;

  initial begin
    #(MAX_CYCLES * 10);
    $display("FAIL watchdog: reached cycle %0d of %0d", cyc, MAX_CYCLES);
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.tx = '0; e.ty = '0; e.hw = '0; e.hh = '0; e.tv = 1'b0; e.due = 0;
    return e;
  endfunction

  // The colour rule, stated directly on the channel values.
  function automatic bit is_match(input logic [15:0] d);
    return (int'(d[15:11]) >= R_MIN) && (int'(d[10:5]) <= G_MAX) && (int'(d[4:0]) <= B_MAX);
  endfunction

  // A random colour that fails at least one threshold.
  function automatic logic [15:0] bg_pixel();
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'($urandom);
    g = 6'($urandom);
    b = 5'($urandom);
    case ($urandom_range(2))
      0:       r = 5'($urandom_range(R_MIN - 1, 0));
      1:       g = 6'($urandom_range(63, G_MAX + 1));
      default: b = 5'($urandom_range(31, B_MAX + 1));
    endcase
    return {r, g, b};
  endfunction

  // A colour within one step of every threshold; matches roughly a third of the time.
  function automatic logic [15:0] near_pixel();
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'($urandom_range(R_MIN + 1, R_MIN - 1));
    g = 6'($urandom_range(G_MAX + 1, G_MAX - 1));
    b = 5'($urandom_range(B_MAX + 1, B_MAX - 1));
    return {r, g, b};
  endfunction

  task automatic fill_bg(input bit black);
    for (int i = 0; i < NPIX; i++) fb[i] = black ? 16'h0000 : bg_pixel();
  endtask

  task automatic fill_rect(input int x0, input int x1, input int y0, input int y1, input logic [15:0] c);
    fill_bg(1'b1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) fb[y * FW + x] = c;
  endtask

  // n distinct threshold-exact matching pixels, never on the first or last raster position.
  task automatic fill_points(input int n);
    int k;
    int idx;
    fill_bg(1'b1);
    k = 0;
    while (k < n) begin
      idx = $urandom_range(NPIX - 2, 1);
      if (fb[idx] == 16'h0000) begin
        fb[idx] = {5'(R_MIN), 6'(G_MAX), 5'(B_MAX)};
        k++;
      end
    end
  endtask

  task automatic fill_random();
    int x0, x1, y0, y1;
    x0 = $urandom_range(FW - 1, 0);
    x1 = $urandom_range(FW - 1, x0);
    y0 = $urandom_range(FH - 1, 0);
    y1 = $urandom_range(FH - 1, y0);
    for (int i = 0; i < NPIX; i++) begin
      if ((i % FW) >= x0 && (i % FW) <= x1 && (i / FW) >= y0 && (i / FW) <= y1 && $urandom_range(1) == 1)
        fb[i] = near_pixel();
      else
        fb[i] = bg_pixel();
    end
  endtask

  // Reference model: bounding box of matches in the buffer, centre and half-size by plain arithmetic.
  task automatic push_expected(input int due);
    int   cnt, mnx, mxx, mny, mxy;
    exp_t e;
    cnt = 0; mnx = FW; mxx = -1; mny = FH; mxy = -1;
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        if (is_match(fb[y * FW + x])) begin
          cnt++;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
    e     = last_exp;
    e.due = due;
    if (cnt >= MIN_PIX) begin
      e.tx = 10'((mnx + mxx) / 2);
      e.ty = 10'((mny + mxy) / 2);
      e.hw = 10'((mxx - mnx) / 2);
      e.hh = 10'((mxy - mny) / 2);
      e.tv = 1'b1;
    end else begin
      e.tv = 1'b0;
    end
    last_exp = e;
    sb_q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(posedge cam_clk); #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 16'($urandom);
  endtask

  // Valid pixels with no frame_start: an idle tracker must ignore them.
  task automatic stray_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge cam_clk); #1;
      frame_start = 1'b0;
      pix_valid   = 1'b1;
      pix_data    = fb[i % NPIX];
    end
  endtask

  // Stream n_send pixels of the buffer; a complete frame registers its expected result.
  task automatic send_frame(input int n_send, input bit coincide, input bit gaps);
    if (!coincide) begin
      @(posedge cam_clk); #1;
      frame_start = 1'b1;
      pix_valid   = 1'b0;
    end
    for (int i = 0; i < n_send; i++) begin
      if (gaps && i != 0 && $urandom_range(7) == 0) idle_cycle();
      @(posedge cam_clk); #1;
      frame_start = coincide && (i == 0);
      pix_valid   = 1'b1;
      pix_data    = fb[i];
      if (i == NPIX - 1) push_expected(cyc + 2);
    end
    repeat (3) idle_cycle();
  endtask

  // Monitor: compare each frame_done against the scoreboard; otherwise outputs must hold.
  always @(negedge cam_clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
        e = sb_q.pop_front();
        check("frame_done_latency", cyc, e.due);
        cur_exp = e;
      end
      if (frame_done) begin
        if (sb_q.size() == 0) begin
          check("frame_done_unexpected", frame_done, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("commit_cycle", cyc, e.due);
          check("track_valid", track_valid, e.tv);
          check("track_x", track_x, e.tx);
          check("track_y", track_y, e.ty);
          check("box_half_w", box_half_w, e.hw);
          check("box_half_h", box_half_h, e.hh);
          cur_exp = e;
        end
      end else begin
        check("outputs_stable", {track_valid, track_x, track_y, box_half_w, box_half_h},
              {cur_exp.tv, cur_exp.tx, cur_exp.ty, cur_exp.hw, cur_exp.hh});
      end
    end
  end

  initial begin
    cur_exp  = zero_exp();
    last_exp = zero_exp();

    // Reset state.
    #2;
    check("rst_track_x", track_x, 10'd0);
    check("rst_track_y", track_y, 10'd0);
    check("rst_half_w", box_half_w, 10'd0);
    check("rst_half_h", box_half_h, 10'd0);
    check("rst_track_valid", track_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    #20;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // All-black frame: no detection.
    fill_bg(1'b1);
    send_frame(NPIX, 1'b0, 1'b0);
    check("black_valid", track_valid, 1'b0);

    // Pure red rectangle x 10..19, y 5..9.
    fill_rect(10, 19, 5, 9, 16'hF800);
    send_frame(NPIX, 1'b0, 1'b1);
    check("rect_x", track_x, 10'd14);
    check("rect_y", track_y, 10'd7);
    check("rect_hw", box_half_w, 10'd4);
    check("rect_hh", box_half_h, 10'd2);
    check("rect_valid", track_valid, 1'b1);

    // Noisy non-matching frame: geometry holds, valid drops.
    fill_bg(1'b0);
    send_frame(NPIX, 1'b0, 1'b1);
    check("hold_x", track_x, 10'd14);
    check("hold_valid", track_valid, 1'b0);

    // Too few matches.
    fill_points(10);
    send_frame(NPIX, 1'b0, 1'b0);
    check("few_valid", track_valid, 1'b0);

    // Opposite corners, first pixel arriving together with frame_start.
    fill_points(MIN_PIX - 2);
    fb[0]        = 16'hF800;
    fb[NPIX - 1] = 16'hF800;
    send_frame(NPIX, 1'b1, 1'b0);
    check("corner_x", track_x, 10'd19);
    check("corner_y", track_y, 10'd14);
    check("corner_hw", box_half_w, 10'd19);
    check("corner_hh", box_half_h, 10'd14);
    check("corner_valid", track_valid, 1'b1);

    // Count threshold boundary.
    fill_points(MIN_PIX - 1);
    send_frame(NPIX, 1'b0, 1'b1);
    fill_points(MIN_PIX);
    send_frame(NPIX, 1'b0, 1'b1);

    // Partial frame abandoned by a new frame_start, then a full frame.
    fill_rect(0, 9, 0, 5, 16'hF800);
    send_frame(300, 1'b0, 1'b1);
    fill_rect(25, 38, 12, 28, {5'(R_MIN), 6'(G_MAX), 5'(B_MAX)});
    send_frame(NPIX, 1'b0, 1'b0);

    // Reset mid-frame, then stray pixels with no frame_start, then a normal frame.
    fill_rect(0, FW - 1, 0, FH - 1, 16'hF800);
    send_frame(400, 1'b0, 1'b0);
    @(posedge cam_clk); #3;
    rst_n    = 1'b0;
    sb_q.delete();
    cur_exp  = zero_exp();
    last_exp = zero_exp();
    #1;
    check("midrst_track_x", track_x, 10'd0);
    check("midrst_track_y", track_y, 10'd0);
    check("midrst_half_w", box_half_w, 10'd0);
    check("midrst_half_h", box_half_h, 10'd0);
    check("midrst_valid", track_valid, 1'b0);
    repeat (2) @(posedge cam_clk);
    #3;
    rst_n = 1'b1;
    stray_pixels(NPIX + 10);
    idle_cycle();
    fill_rect(3, 30, 2, 20, 16'hF81F & 16'hF800);
    send_frame(NPIX, 1'b0, 1'b1);

    // Randomised frames.
    repeat (6) begin
      fill_random();
      send_frame(NPIX, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (5) idle_cycle();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_tracker_core.md
COLOR_TRACKER_CORE -- requirements
Module: color_tracker_core

Interface
REQ-001 Parameter R_MIN, 20, minimum 5-bit red value for a pixel to match.
REQ-002 Parameter G_MAX, 24, maximum 6-bit green value for a pixel to match.
REQ-003 Parameter B_MAX, 12, maximum 5-bit blue value for a pixel to match.
REQ-004 Parameter MIN_PIXELS, 16, minimum matched-pixel count for a valid detection.
REQ-005 cam_clk  in  1  sole clock; all logic rising-edge; pixel stream is synchronous to it.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 frame_start  in  1  one-cycle pulse marking the start of a 320x240 frame.
REQ-008 pix_valid  in  1  pix_data holds a valid pixel this cycle.
REQ-009 pix_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0]; raster order.
REQ-010 track_x  out  10  object centre X, 320x240 coordinates.
REQ-011 track_y  out  10  object centre Y, 320x240 coordinates.
REQ-012 box_half_w  out  10  half bounding-box width.
REQ-013 box_half_h  out  10  half bounding-box height.
REQ-014 track_valid  out  1  last completed frame contained a valid detection.
REQ-015 frame_done  out  1  one-cycle pulse when outputs update.

Function
REQ-016 A pixel SHALL match iff R>=R_MIN and G<=G_MAX and B<=B_MAX.
REQ-017 FSM states SHALL be IDLE, ACCUM, COMMIT; IDLE ignores pix_valid.
REQ-018 frame_start in any state SHALL clear x/y counters and accumulators and enter ACCUM.
REQ-019 frame_start arriving in ACCUM SHALL discard the partial frame: outputs unchanged, no frame_done.
REQ-020 frame_start coincident with pix_valid SHALL treat that pixel as (0,0) of the new frame.
REQ-021 In ACCUM each pix_valid SHALL advance x 0..319; at x=319, x wraps to 0 and y increments.
REQ-022 Accumulators SHALL track min_x, max_x, min_y, max_y (cleared to min=511, max=0) and a 17-bit saturating match count.
REQ-023 Accepting pixel (319,239) SHALL move ACCUM->COMMIT; COMMIT lasts one cycle then goes to IDLE.
REQ-024 Latency: last pixel accepted in cycle N; new outputs and frame_done visible in cycle N+2.
REQ-025 At commit: track_x=(min_x+max_x)>>1, track_y=(min_y+max_y)>>1, box_half_w=(max_x-min_x)>>1, box_half_h=(max_y-min_y)>>1, using 11-bit intermediate sums.
REQ-026 At commit, if count<MIN_PIXELS: track_valid=0; track_x, track_y, box_half_w and box_half_h hold prior values.
REQ-027 Outputs SHALL change only at commit and remain stable for the whole following frame.
REQ-028 frame_done SHALL pulse at every commit, valid or not.

Reset
REQ-029 rst_n low SHALL force IDLE and all outputs to 0 (track_valid=0, frame_done=0) asynchronously.
REQ-030 Reset mid-frame SHALL abandon accumulation; tracking resumes only after the next frame_start.

Structure
REQ-031 Package tracker_pkg SHALL hold FRAME_W=320, FRAME_H=240, the state encoding, and RGB565 field bit positions.
REQ-032 Sub-module pixel_classifier (combinational, parameterised thresholds) SHALL implement REQ-016.

Verification
REQ-033 All-black frame -> frame_done pulse, track_valid=0, other outputs hold prior values.
REQ-034 Red (pix_data=16'hF800) rectangle x 100..139, y 50..69 (800 px) -> track_x=119, track_y=59, box_half_w=19, box_half_h=9, track_valid=1 at cycle N+2.
REQ-035 10 matching pixels only (MIN_PIXELS=16) -> track_valid=0, frame_done pulses.
REQ-036 Red pixels at (0,0) and (319,239) only, MIN_PIXELS=2 -> track_x=159, track_y=119, box_half_w=159, box_half_h=119.
REQ-037 frame_start after 1000 pixels -> no frame_done, outputs unchanged; next full frame commits normally.
REQ-038 rst_n low mid-frame -> all outputs 0 immediately; pixels ignored until frame_start.
